codec_cfg_sequencer: RTL and testbench

Parametrised successor to the audio-codec configuration/volume block. After reset it streams a fixed WM8731-style init table as 24-bit {device, register, data} words to an I2C master over a valid/ready handshake. It then holds an N-channel volume/mute state and issues only the register writes needed when volume, mute or channel enables change. It sits between the front-panel inputs (keys, switches) and the I2C master, and exports level and mute status for the 7-segment display and LEDs.

---
 rtl/codec_cfg_sequencer_pkg.sv | 48 ++++
 rtl/codec_cfg_sequencer_if.sv | 16 +
 rtl/codec_cfg_sequencer_vol_ctrl.sv | 82 ++++++++
 rtl/codec_cfg_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_codec_cfg_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_cfg_sequencer_pkg.sv
// codec_cfg_pkg: shared types and constants for the codec configuration
// sequencer.
//   seq_state_t  - sequencer FSM states (INIT, RUN, UPD)
//   W_*          - fixed init-table words {reg_addr, data}
//   REG_LHP      - register address of channel 0 volume (channel c at +2*c)
//   REG_ACTIVE   - codec activate register
//   table_len()  - number of init-table entries for a given channel count
package codec_cfg_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_UPD  = 2'd2
  } seq_state_t;

  localparam logic [7:0] REG_LHP    = 8'h04;
  localparam logic [7:0] REG_ACTIVE = 8'h12;

  // Fixed words streamed ahead of the per-channel volume words.
  localparam logic [15:0] W_POWER  = 16'h0C00;
  localparam logic [15:0] W_FORMAT = 16'h0EC2;
  localparam logic [15:0] W_APATH  = 16'h0838;
  localparam logic [15:0] W_SAMPLE = 16'h1000;
  localparam logic [15:0] W_LLINE  = 16'h0017;
  localparam logic [15:0] W_RLINE  = 16'h0217;
  localparam logic [15:0] W_ACTIVE = {REG_ACTIVE, 8'h01};

  localparam int NUM_FIXED = 6;

  function automatic int table_len(input int num_ch);
    return NUM_FIXED + num_ch + 1;
  endfunction

  function automatic logic [15:0] fixed_word(input int i);
    logic [15:0] w;
    case (i)
      0:       w = W_POWER;
      1:       w = W_FORMAT;
      2:       w = W_APATH;
      3:       w = W_SAMPLE;
      4:       w = W_LLINE;
      5:       w = W_RLINE;
      default: w = W_ACTIVE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// codec_cfg_sequencer_if: write-word channel from the sequencer to the I2C
// master.
//   cmd_valid - word available (sequencer drives)
//   cmd_ready - I2C master accepts the word
//   cmd_data  - {device, register, data}
// Handshake: a word transfers on the rising clock edge where cmd_valid and
// cmd_ready are both high; while cmd_valid=1 and cmd_ready=0 the word must
// hold, and cmd_valid may not drop until the word has transferred.
interface codec_cfg_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/codec_cfg_sequencer_vol_ctrl.sv
// vol_ctrl: volume/mute state for the codec sequencer.
//   clk, rst_n          - clock, asynchronous active-low reset
//   vol_up/vol_dn       - single-cycle step pulses (saturating)
//   mute_tgl            - single-cycle mute toggle pulse
//   vol_level           - current unmuted volume code
//   mute                - current mute state
//   level_idx           - (vol_level-VOL_MIN)/VOL_STEP saturated to 15
//   changed             - vol_level or mute updates on this clock edge
// Arbitration: mute_tgl beats any vol pulse; vol_up with vol_dn cancels;
// vol pulses are ignored while muted so unmute restores the old level.
module vol_ctrl #(
  parameter int VOL_W       = 7,
  parameter int VOL_MIN     = 'h30,
  parameter int VOL_MAX     = 'h7F,
  parameter int VOL_DEFAULT = 'h60,
  parameter int VOL_STEP    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vol_up,
  input  logic             vol_dn,
  input  logic             mute_tgl,
  output logic [VOL_W-1:0] vol_level,
  output logic             mute,
  output logic [3:0]       level_idx,
  output logic             changed
);

  localparam logic [VOL_W:0]   MIN_X  = (VOL_W+1)'(VOL_MIN);
  localparam logic [VOL_W:0]   MAX_X  = (VOL_W+1)'(VOL_MAX);
  localparam logic [VOL_W:0]   STEP_X = (VOL_W+1)'(VOL_STEP);
  localparam logic [VOL_W:0]   IDX_MX = (VOL_W+1)'(15);
  localparam logic [VOL_W-1:0] DEF_V  = VOL_W'(VOL_DEFAULT);

  logic [VOL_W:0]   up_sum;
  logic [VOL_W:0]   dn_diff;
  logic [VOL_W:0]   offset;
  logic [VOL_W:0]   quot;
  logic [VOL_W-1:0] vol_d;
  logic             mute_d;

  always_comb begin
    // One extra bit so the step cannot wrap before saturation.
    up_sum  = {1'b0, vol_level} + STEP_X;
    dn_diff = {1'b0, vol_level} - STEP_X;
    vol_d   = vol_level;
    mute_d  = mute;
    if (mute_tgl) begin
      mute_d = !mute;
    end else if (!mute && vol_up && !vol_dn) begin
      vol_d = (up_sum > MAX_X) ? MAX_X[VOL_W-1:0] : up_sum[VOL_W-1:0];
    end else if (!mute && vol_dn && !vol_up) begin
      // Top bit set means the subtraction went below zero.
      vol_d = (dn_diff[VOL_W] || dn_diff < MIN_X) ? MIN_X[VOL_W-1:0]
                                                  : dn_diff[VOL_W-1:0];
    end
    changed = (vol_d != vol_level) || (mute_d != mute);
  end

  always_comb begin
    offset = {1'b0, vol_level} - MIN_X;
    quot   = offset / STEP_X;
    if ({1'b0, vol_level} < MIN_X) begin
      level_idx = 4'd0;
    end else if (quot > IDX_MX) begin
      level_idx = 4'd15;
    end else begin
      level_idx = quot[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol_level <= DEF_V;
      mute      <= 1'b0;
    end else begin
      vol_level <= vol_d;
      mute      <= mute_d;
    end
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: streams the codec init table after reset, then
// writes per-channel volume registers only when volume, mute or a channel
// enable changes.
//   CLOCK, RESET   - clock, asynchronous active-low reset
//   vol_up/vol_dn  - volume step pulses; mute_tgl - mute toggle pulse
//   ch_en          - per-channel enable level
//   cmd            - write-word channel to the I2C master (master modport)
//   init_done      - init table fully accepted
//   busy           - write pending/in flight or init not finished
//   mute, vol_level, level_idx - volume status for display/LEDs
//   fsm_state      - current sequencer state (debug)
// Optional macro SOFT_RAMP_EN: each channel tracks its last written code and
// UPD moves it one code per accepted word toward the target until equal.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_CH      = 2,
  parameter int         VOL_W       = 7,
  parameter int         VOL_MIN     = 'h30,
  parameter int         VOL_MAX     = 'h7F,
  parameter int         VOL_DEFAULT = 'h60,
  parameter int         VOL_STEP    = 4,
  parameter logic [7:0] DEV_ADDR    = 8'h34
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    vol_up,
  input  logic                    vol_dn,
  input  logic                    mute_tgl,
  input  logic [NUM_CH-1:0]       ch_en,
  codec_cfg_sequencer_if.master   cmd,
  output logic                    init_done,
  output logic                    busy,
  output logic                    mute,
  output logic [VOL_W-1:0]        vol_level,
  output logic [3:0]              level_idx,
  output seq_state_t              fsm_state
);

  localparam int         LEN      = table_len(NUM_CH);
  localparam logic [3:0] LAST_IDX = 4'(LEN - 1);

  seq_state_t        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [23:0]       data_q, data_d;
  logic [NUM_CH-1:0] dirty_q, dirty_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] ch_en_q;
  logic              vol_chg;
  logic              accept;
  logic [NUM_CH-1:0] dirty_ev;
  logic [VOL_W-1:0]  chan_vol [NUM_CH];
  logic [3:0]        tbl_idx;
  logic [15:0]       tbl_word;
  logic              tbl_load;
  logic              upd_found;
  logic [NUM_CH-1:0] upd_mask;
  logic [15:0]       upd_word;
`ifdef SOFT_RAMP_EN
  logic [VOL_W-1:0]  wr_q [NUM_CH];
  logic [VOL_W-1:0]  wr_d [NUM_CH];
  logic [VOL_W-1:0]  upd_code;
  logic              upd_done;
`endif

  vol_ctrl #(
    .VOL_W      (VOL_W),
    .VOL_MIN    (VOL_MIN),
    .VOL_MAX    (VOL_MAX),
    .VOL_DEFAULT(VOL_DEFAULT),
    .VOL_STEP   (VOL_STEP)
  ) u_vol_ctrl (
    .clk      (CLOCK),
    .rst_n    (RESET),
    .vol_up   (vol_up),
    .vol_dn   (vol_dn),
    .mute_tgl (mute_tgl),
    .vol_level(vol_level),
    .mute     (mute),
    .level_idx(level_idx),
    .changed  (vol_chg)
  );

  assign accept        = valid_q && cmd.cmd_ready;
  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_data  = data_q;
  assign init_done     = done_q;
  assign busy          = busy_q;
  assign fsm_state     = state_q;

  // Enables are compared against their registered copy, which is also what
  // chan_vol uses, so a dirty bit and the value it stands for move together.
  assign dirty_ev = {NUM_CH{vol_chg}} | (ch_en ^ ch_en_q);

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      chan_vol[c] = (mute || !ch_en_q[c]) ? '0 : vol_level;
    end
  end

  // Table word to load: the current entry when idle, the next one when the
  // current entry is being accepted (back-to-back streaming).
  always_comb begin
    tbl_idx  = valid_q ? idx_q + 4'd1 : idx_q;
    tbl_word = W_ACTIVE;
    if (int'(tbl_idx) < NUM_FIXED) begin
      tbl_word = fixed_word(int'(tbl_idx));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(tbl_idx) == NUM_FIXED + c) begin
        tbl_word = {REG_LHP + 8'(2 * c), 8'(chan_vol[c])};
      end
    end
  end

  // Lowest-index dirty channel wins.
  always_comb begin
    upd_found = 1'b0;
    upd_mask  = '0;
    upd_word  = 16'h0000;
`ifdef SOFT_RAMP_EN
    upd_code  = '0;
    upd_done  = 1'b0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (dirty_q[c] && !upd_found) begin
        upd_found   = 1'b1;
        upd_mask[c] = 1'b1;
`ifdef SOFT_RAMP_EN
        if (wr_q[c] < chan_vol[c]) begin
          upd_code = wr_q[c] + 1'b1;
        end else if (wr_q[c] > chan_vol[c]) begin
          upd_code = wr_q[c] - 1'b1;
        end else begin
          upd_code = wr_q[c];
        end
        upd_done = (upd_code == chan_vol[c]);
        upd_word = {REG_LHP + 8'(2 * c), 8'(upd_code)};
`else
        upd_word = {REG_LHP + 8'(2 * c), 8'(chan_vol[c])};
`endif
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    data_d   = data_q;
    dirty_d  = dirty_q;
    done_d   = done_q;
    tbl_load = 1'b0;
`ifdef SOFT_RAMP_EN
    for (int c = 0; c < NUM_CH; c++) begin
      wr_d[c] = wr_q[c];
    end
`endif
    case (state_q)
      ST_INIT: begin
        if (!valid_q) begin
          valid_d  = 1'b1;
          data_d   = {DEV_ADDR, tbl_word};
          tbl_load = 1'b1;
        end else if (accept) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            state_d = ST_RUN;
            done_d  = 1'b1;
            dirty_d = '0;
          end else begin
            idx_d    = idx_q + 4'd1;
            data_d   = {DEV_ADDR, tbl_word};
            tbl_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (|dirty_q) begin
          state_d = ST_UPD;
        end
      end
      ST_UPD: begin
        if (accept) begin
          valid_d = 1'b0;
          state_d = ST_RUN;
        end else if (!valid_q) begin
          if (upd_found) begin
            valid_d = 1'b1;
            data_d  = {DEV_ADDR, upd_word};
`ifdef SOFT_RAMP_EN
            if (upd_done) begin
              dirty_d = dirty_q & ~upd_mask;
            end
            for (int c = 0; c < NUM_CH; c++) begin
              if (upd_mask[c]) begin
                wr_d[c] = upd_code;
              end
            end
`else
            dirty_d = dirty_q & ~upd_mask;
`endif
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
`ifdef SOFT_RAMP_EN
    for (int c = 0; c < NUM_CH; c++) begin
      if (tbl_load && int'(tbl_idx) == NUM_FIXED + c) begin
        wr_d[c] = chan_vol[c];
      end
    end
`endif
    // A new event always re-arms the channel, even when its word is being
    // captured on this edge, so the final value is written later.
    dirty_d = dirty_d | dirty_ev;
    busy_d  = valid_d || (|dirty_d) || !done_d;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_INIT;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      data_q  <= 24'h000000;
      dirty_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ch_en_q <= '0;
`ifdef SOFT_RAMP_EN
      for (int c = 0; c < NUM_CH; c++) begin
        wr_q[c] <= '0;
      end
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      dirty_q <= dirty_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ch_en_q <= ch_en;
`ifdef SOFT_RAMP_EN
      for (int c = 0; c < NUM_CH; c++) begin
        wr_q[c] <= wr_d[c];
      end
`endif
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
module tb_codec_cfg_sequencer;
  import codec_cfg_pkg::*;

  localparam int NUM_CH = 2;

  // clock / reset
  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic              vol_up = 1'b0;
  logic              vol_dn = 1'b0;
  logic              mute_tgl = 1'b0;
  logic [NUM_CH-1:0] ch_en = '1;
  logic              init_done, busy, mute;
  logic [6:0]        vol_level;
  logic [3:0]        level_idx;
  seq_state_t        fsm_state;

  codec_cfg_sequencer_if cmd_if ();

  codec_cfg_sequencer dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .vol_up   (vol_up),
    .vol_dn   (vol_dn),
    .mute_tgl (mute_tgl),
    .ch_en    (ch_en),
    .cmd      (cmd_if),
    .init_done(init_done),
    .busy     (busy),
    .mute     (mute),
    .vol_level(vol_level),
    .level_idx(level_idx),
    .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ready driver: 0 = always ready, 1 = random, 2 = held low
  int rdy_mode = 0;
  always @(posedge CLOCK) begin
    #1;
    case (rdy_mode)
      0:       cmd_if.cmd_ready = 1'b1;
      1:       cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
      default: cmd_if.cmd_ready = 1'b0;
    endcase
  end

  // scoreboard + codec register shadow
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [7:0]  shadow [NUM_CH];
  bit          mon_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [23:0] prev_data = '0;

  always @(negedge CLOCK) begin
    if (mon_en && RESET) begin
      if (stall_prev) begin
        check("hold_valid", 32'(cmd_if.cmd_valid), 32'd1);
        check("hold_data", 32'(cmd_if.cmd_data), 32'(prev_data));
      end
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        obs_q.push_back(cmd_if.cmd_data);
        for (int c = 0; c < NUM_CH; c++) begin
          if (cmd_if.cmd_data[15:8] == 8'(4 + 2 * c)) shadow[c] = cmd_if.cmd_data[7:0];
        end
      end
      stall_prev = cmd_if.cmd_valid && !cmd_if.cmd_ready;
      prev_data  = cmd_if.cmd_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // reference model
  int                m_vol = 'h60;
  bit                m_mute = 1'b0;
  logic [NUM_CH-1:0] m_en = '1;

  function automatic logic [7:0] m_chan(input int c);
    return (m_mute || !m_en[c]) ? 8'h00 : 8'(m_vol);
  endfunction

  function automatic logic [3:0] m_idx();
    int q;
    q = (m_vol - 'h30) / 4;
    return (q > 15) ? 4'd15 : 4'(q);
  endfunction

  task automatic model_event(input bit up, input bit dn, input bit tgl,
                             input logic [NUM_CH-1:0] en, input bit push);
    bit chg;
    int nv;
    logic [NUM_CH-1:0] ed;
    chg = 1'b0;
    nv  = m_vol;
    if (tgl) begin
      m_mute = !m_mute;
      chg = 1'b1;
    end else if (!m_mute && up && !dn) begin
      nv = (m_vol + 4 > 'h7F) ? 'h7F : m_vol + 4;
    end else if (!m_mute && dn && !up) begin
      nv = (m_vol - 4 < 'h30) ? 'h30 : m_vol - 4;
    end
    if (nv != m_vol) chg = 1'b1;
    m_vol = nv;
    ed = en ^ m_en;
    m_en = en;
    if (push) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (chg || ed[c]) exp_q.push_back({8'h34, 8'(4 + 2 * c), m_chan(c)});
      end
    end
  endtask

  task automatic push_init_table();
    exp_q.push_back(24'h340C00);
    exp_q.push_back(24'h340EC2);
    exp_q.push_back(24'h340838);
    exp_q.push_back(24'h341000);
    exp_q.push_back(24'h340017);
    exp_q.push_back(24'h340217);
    for (int c = 0; c < NUM_CH; c++) exp_q.push_back({8'h34, 8'(4 + 2 * c), m_chan(c)});
    exp_q.push_back(24'h341201);
  endtask

  // driver tasks
  task automatic drive_cycle(input bit up, input bit dn, input bit tgl,
                             input logic [NUM_CH-1:0] en, input bit push);
    @(posedge CLOCK);
    #1;
    vol_up = up;
    vol_dn = dn;
    mute_tgl = tgl;
    ch_en = en;
    model_event(up, dn, tgl, en, push);
  endtask

  task automatic release_pulses();
    @(posedge CLOCK);
    #1;
    vol_up = 1'b0;
    vol_dn = 1'b0;
    mute_tgl = 1'b0;
  endtask

  task automatic single_event(input bit up, input bit dn, input bit tgl,
                              input logic [NUM_CH-1:0] en);
    drive_cycle(up, dn, tgl, en, 1'b1);
    release_pulses();
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    repeat (3) @(negedge CLOCK);
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge CLOCK);
      if (!busy && !cmd_if.cmd_valid) idle = 1'b1;
    end
    if (!idle) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic state_check(input string tag);
    check({tag, "_vol"}, 32'(vol_level), 32'(m_vol));
    check({tag, "_mute"}, 32'(mute), 32'(m_mute));
    check({tag, "_lvl"}, 32'(level_idx), 32'(m_idx()));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    for (int c = 0; c < NUM_CH; c++) check({tag, "_reg"}, 32'(shadow[c]), 32'(m_chan(c)));
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    end
    obs_q.delete();
    exp_q.delete();
    state_check(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int k;
    logic [NUM_CH-1:0] en;

    // reset values
    repeat (3) @(negedge CLOCK);
    check("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("rst_data", 32'(cmd_if.cmd_data), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mute", 32'(mute), 32'd0);
    check("rst_vol", 32'(vol_level), 32'h60);
    check("rst_lvl", 32'(level_idx), 32'd12);
    check("rst_state", 32'(fsm_state), 32'(ST_INIT));

    // init table with a 5-cycle stall on the third word
    push_init_table();
    mon_en = 1'b1;
    RESET = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge CLOCK);
      if (cmd_if.cmd_valid && cmd_if.cmd_data == 24'h340EC2) found = 1'b1;
    end
    check("stall_seen", 32'(found), 32'd1);
    rdy_mode = 2;
    repeat (5) begin
      @(negedge CLOCK);
      check("stall_valid", 32'(cmd_if.cmd_valid), 32'd1);
      check("stall_data", 32'(cmd_if.cmd_data), 32'h340838);
    end
    rdy_mode = 0;
    wait_idle("init");
    drain_check("init");
    check("init_done", 32'(init_done), 32'd1);
    check("init_state", 32'(fsm_state), 32'(ST_RUN));

    // directed volume / mute / enable cases under random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      single_event(1'b1, 1'b0, 1'b0, ch_en);
      wait_idle("vol_up");
      drain_check("vol_up");
    end
    check("sat_vol", 32'(vol_level), 32'h7F);
    check("sat_lvl", 32'(level_idx), 32'd15);

    single_event(1'b0, 1'b0, 1'b1, ch_en);
    wait_idle("mute_on");
    drain_check("mute_on");
    single_event(1'b1, 1'b0, 1'b0, ch_en);
    wait_idle("muted_up");
    drain_check("muted_up");
    single_event(1'b0, 1'b0, 1'b1, ch_en);
    wait_idle("mute_off");
    drain_check("mute_off");
    single_event(1'b1, 1'b1, 1'b0, ch_en);
    wait_idle("up_dn");
    drain_check("up_dn");
    single_event(1'b0, 1'b0, 1'b0, 2'b01);
    wait_idle("ch_en");
    drain_check("ch_en");
    single_event(1'b0, 1'b0, 1'b0, 2'b11);
    wait_idle("ch_en_back");
    drain_check("ch_en_back");

    // random single events, exact write sequence
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 6);
      en = ch_en;
      case (k)
        0:       single_event(1'b1, 1'b0, 1'b0, en);
        1, 2:    single_event(1'b0, 1'b1, 1'b0, en);
        3:       single_event(1'b1, 1'b1, 1'b0, en);
        4:       single_event(1'b0, 1'b0, 1'b1, en);
        5:       single_event($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 1'b1, en);
        default: single_event(1'b0, 1'b0, 1'b0, NUM_CH'($urandom_range(0, 3)));
      endcase
      wait_idle("rand");
      drain_check("rand");
    end

    // back-to-back bursts: only the final register contents are defined
    for (int r = 0; r < 12; r++) begin
      k = $urandom_range(3, 8);
      for (int i = 0; i < k; i++) begin
        drive_cycle($urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 4) == 0, NUM_CH'($urandom_range(0, 3)), 1'b0);
      end
      release_pulses();
      wait_idle("burst");
      obs_q.delete();
      state_check("burst");
    end

    // reset during word 5 restarts the table
    rdy_mode = 0;
    @(negedge CLOCK);
    mon_en = 1'b0;
    RESET = 1'b0;
    m_vol = 'h60;
    m_mute = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge CLOCK);
      if (cmd_if.cmd_valid && cmd_if.cmd_data == 24'h340017) found = 1'b1;
    end
    check("w5_seen", 32'(found), 32'd1);
    #1;
    RESET = 1'b0;
    #1;
    check("mid_rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("mid_rst_data", 32'(cmd_if.cmd_data), 32'd0);
    check("mid_rst_done", 32'(init_done), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'(ST_INIT));
    @(negedge CLOCK);
    obs_q.delete();
    exp_q.delete();
    push_init_table();
    mon_en = 1'b1;
    RESET = 1'b1;
    wait_idle("restart");
    drain_check("restart");
    check("restart_done", 32'(init_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
